// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the flash sample reader slice.
package flash_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DV,
        DONE
    } flash_rd_state_t;

    localparam int         FLASH_ADDR_W        = 23;
    localparam int         SAMPLE_W            = 16;
    localparam logic [3:0] FLASH_BYTEEN_ALL    = 4'b1111;
    localparam int         TIMEOUT_CYC_DEFAULT = 255;

endpackage

// File: rtl/rd_watchdog.sv
// Load/count/expire counter that bounds how long a flash read may stay outstanding.
module rd_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Fires on the TIMEOUT_CYC-th cycle spent waiting.
    assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flash_sample_reader.sv
// Avalon-MM flash reader returning one 16-bit sample per request, reusing the held word for the second half.
// Optional read watchdog enabled by defining FLASH_RD_TIMEOUT_EN.
module flash_sample_reader
    import flash_reader_pkg::*;
#(
    parameter int ADDR_W      = FLASH_ADDR_W,
    parameter int SAMPLE_W    = flash_reader_pkg::SAMPLE_W,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  is_old,
    input  logic                  back_mode,
    output logic                  flash_mem_read,
    output logic [ADDR_W-1:0]     flash_mem_address,
    output logic [3:0]            flash_mem_byteenable,
    input  logic                  flash_mem_waitrequest,
    input  logic                  flash_mem_readdatavalid,
    input  logic [2*SAMPLE_W-1:0] flash_mem_readdata,
    output logic [SAMPLE_W-1:0]   sample,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  rd_error
);
    flash_rd_state_t       state_q, state_d;
    logic                  read_q, read_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  overrun_q, overrun_d;
    logic [2*SAMPLE_W-1:0] word_q, word_d;
    logic                  word_held_q, word_held_d;
    logic                  reuse_q, reuse_d;
    logic                  back_q, back_d;
    logic                  wd_load;
    logic                  wd_expired;

`ifdef FLASH_RD_TIMEOUT_EN
    logic rd_error_q, rd_error_d;

    rd_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rd_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wd_load),
        .run     ((state_q == REQ) || (state_q == WAIT_DV)),
        .expired (wd_expired)
    );

    assign rd_error = rd_error_q;
`else
    // No watchdog: the FSM waits on the flash indefinitely.
    assign wd_expired = 1'b0;
    assign rd_error   = 1'b0 & (TIMEOUT_CYC != 0);
`endif

    always_comb begin
        state_d        = state_q;
        read_d         = read_q;
        addr_d         = addr_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        overrun_d      = overrun_q | (start && (state_q != IDLE));
        word_d         = word_q;
        word_held_d    = word_held_q;
        reuse_d        = reuse_q;
        back_d         = back_q;
        wd_load        = 1'b0;
`ifdef FLASH_RD_TIMEOUT_EN
        rd_error_d     = rd_error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    back_d  = back_mode;
                    // A reuse request with nothing held falls back to a fresh read.
                    reuse_d = is_old && word_held_q;
                    if (reuse_d) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                        read_d  = 1'b1;
                        wd_load = 1'b1;
                    end
                end
            end
            REQ: begin
                if (!flash_mem_waitrequest) begin
                    read_d = 1'b0;
                    if (flash_mem_readdatavalid) begin
                        word_d      = flash_mem_readdata;
                        word_held_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = WAIT_DV;
                    end
                end
            end
            WAIT_DV: begin
                if (flash_mem_readdatavalid) begin
                    word_d      = flash_mem_readdata;
                    word_held_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Fresh forward and reuse reverse take the low half; the other two take the high half.
                sample_d       = (reuse_q ^ back_q) ? word_q[2*SAMPLE_W-1:SAMPLE_W]
                                                    : word_q[SAMPLE_W-1:0];
                sample_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef FLASH_RD_TIMEOUT_EN
        if (wd_expired && ((state_q == REQ) || (state_q == WAIT_DV))) begin
            read_d         = 1'b0;
            rd_error_d     = 1'b1;
            sample_d       = '0;
            sample_valid_d = 1'b1;
            word_held_d    = 1'b0;
            state_d        = IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            read_q         <= 1'b0;
            addr_q         <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            word_held_q    <= 1'b0;
            reuse_q        <= 1'b0;
            back_q         <= 1'b0;
`ifdef FLASH_RD_TIMEOUT_EN
            rd_error_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            read_q         <= read_d;
            addr_q         <= addr_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
            word_q         <= word_d;
            word_held_q    <= word_held_d;
            reuse_q        <= reuse_d;
            back_q         <= back_d;
`ifdef FLASH_RD_TIMEOUT_EN
            rd_error_q     <= rd_error_d;
`endif
        end
    end

    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = FLASH_BYTEEN_ALL;
    assign sample               = sample_q;
    assign sample_valid         = sample_valid_q;
    assign busy                 = (state_q != IDLE);
    assign overrun              = overrun_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Scoreboard bench for flash_sample_reader; the watchdog scenario runs when FLASH_RD_TIMEOUT_EN is defined.
module tb_flash_sample_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [22:0] addr;
    logic        is_old;
    logic        back_mode;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic        flash_mem_waitrequest;
    logic        flash_mem_readdatavalid;
    logic [31:0] flash_mem_readdata;
    logic [15:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        overrun;
    logic        rd_error;

    int          nassert = 0;
    int          nfail   = 0;
    int          read_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_s;
    logic [31:0] tb_word = '0;
    bit          tb_held = 1'b0;

    flash_sample_reader dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start                   (start),
        .addr                    (addr),
        .is_old                  (is_old),
        .back_mode               (back_mode),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .flash_mem_readdata      (flash_mem_readdata),
        .sample                  (sample),
        .sample_valid            (sample_valid),
        .busy                    (busy),
        .overrun                 (overrun),
        .rd_error                (rd_error)
    );

    always #5 clk = ~clk;

    // Accepted Avalon reads.
    always @(posedge clk) begin
        if (rst_n && flash_mem_read && !flash_mem_waitrequest) begin
            read_cnt <= read_cnt + 1;
        end
    end

    // Scoreboard: every sample_valid pulse must match the oldest expected sample.
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            nassert++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL sample_unexpected: sample_valid with sample=%h, required no pulse", sample);
            end else begin
                exp_s = exp_q.pop_front();
                if (sample !== exp_s) begin
                    nfail++;
                    $display("FAIL sample_value: got %h, required %h", sample, exp_s);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "global timeout");
    end

    // Issues one request from the current negedge and plays the flash side; ends on the sample_valid negedge.
    task automatic request(input logic [22:0] a, input logic old, input logic back,
                           input logic [31:0] data, input int stall);
        int          cyc;
        int          rc0;
        logic        fresh;
        logic [15:0] e;
        fresh = !(old && tb_held);
        if (fresh) begin
            e       = back ? data[31:16] : data[15:0];
            tb_word = data;
            tb_held = 1'b1;
        end else begin
            e = back ? tb_word[15:0] : tb_word[31:16];
        end
        exp_q.push_back(e);
        rc0 = read_cnt;
        start = 1'b1; addr = a; is_old = old; back_mode = back;
        flash_mem_waitrequest = (stall > 0);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        if (fresh) begin
            nassert++;
            if (flash_mem_read !== 1'b1 || flash_mem_address !== a) begin
                nfail++;
                $display("FAIL read_issue: read=%b addr=%h, required 1 / %h", flash_mem_read, flash_mem_address, a);
            end
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                cyc++;
                nassert++;
                if (flash_mem_read !== 1'b1 || flash_mem_address !== a) begin
                    nfail++;
                    $display("FAIL stall_hold: cycle %0d read=%b addr=%h, required 1 / %h", s, flash_mem_read, flash_mem_address, a);
                end
            end
            flash_mem_waitrequest = 1'b0;
            @(negedge clk);
            cyc++;
            nassert++;
            if (flash_mem_read !== 1'b0) begin
                nfail++;
                $display("FAIL read_drop: read=%b after acceptance, required 0", flash_mem_read);
            end
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata      = data;
            @(negedge clk);
            cyc++;
            flash_mem_readdatavalid = 1'b0;
            flash_mem_readdata      = '0;
            @(negedge clk);
            cyc++;
        end else begin
            nassert++;
            if (flash_mem_read !== 1'b0) begin
                nfail++;
                $display("FAIL reuse_no_read: read=%b, required 0", flash_mem_read);
            end
            @(negedge clk);
            cyc++;
        end
        nassert++;
        if (sample_valid !== 1'b1 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL latency: after %0d cycles sample_valid=%b busy=%b, required 1 / 0", cyc, sample_valid, busy);
        end
        nassert++;
        if ((read_cnt - rc0) != (fresh ? 1 : 0)) begin
            nfail++;
            $display("FAIL read_count: %0d reads, required %0d", read_cnt - rc0, fresh ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; addr = '0; is_old = 1'b0; back_mode = 1'b0;
        flash_mem_waitrequest = 1'b0; flash_mem_readdatavalid = 1'b0; flash_mem_readdata = '0;
        repeat (3) @(negedge clk);
        nassert++;
        if ({flash_mem_read, flash_mem_address, sample, sample_valid, busy, overrun, rd_error} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs: read=%b addr=%h sample=%h vld=%b busy=%b ovr=%b err=%b, required all 0",
                     flash_mem_read, flash_mem_address, sample, sample_valid, busy, overrun, rd_error);
        end
        nassert++;
        if (flash_mem_byteenable !== 4'b1111) begin
            nfail++;
            $display("FAIL byteenable: got %b, required 1111", flash_mem_byteenable);
        end
        tb_held = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward();
        request(23'h00010, 1'b0, 1'b0, 32'hBEEF1234, 0);
        @(negedge clk);
        request(23'h00010, 1'b1, 1'b0, 32'h0, 0);
        @(negedge clk);
    endtask

    task automatic test_back_mode();
        request(23'h00200, 1'b0, 1'b1, 32'hAAAA5555, 0);
        @(negedge clk);
        request(23'h00200, 1'b1, 1'b1, 32'h0, 0);
        @(negedge clk);
    endtask

    task automatic test_stall();
        request(23'h7ABCD, 1'b0, 1'b0, 32'h0F0F8001, 5);
        @(negedge clk);
    endtask

    // Starts issued in the sample_valid cycle are accepted.
    task automatic test_back_to_back();
        request(23'h01000, 1'b0, 1'b0, 32'h7FFF8000, 0);
        request(23'h01000, 1'b1, 1'b0, 32'h0, 0);
        request(23'h01001, 1'b0, 1'b1, 32'h13579BDF, 2);
        request(23'h01001, 1'b1, 1'b1, 32'h0, 0);
        @(negedge clk);
    endtask

    task automatic test_overrun();
        int rc0;
        test_reset();
        rc0 = read_cnt;
        exp_q.push_back(16'h5678);
        start = 1'b1; addr = 23'h00040; is_old = 1'b1; back_mode = 1'b0;
        flash_mem_waitrequest = 1'b0;
        @(negedge clk);
        nassert++;
        if (flash_mem_read !== 1'b1 || flash_mem_address !== 23'h00040) begin
            nfail++;
            $display("FAIL first_is_old_fresh: read=%b addr=%h, required 1 / 00040", flash_mem_read, flash_mem_address);
        end
        addr = 23'h00999;
        @(negedge clk);
        start = 1'b0;
        nassert++;
        if (overrun !== 1'b1) begin
            nfail++;
            $display("FAIL overrun_set: got %b, required 1", overrun);
        end
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'h12345678;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = '0;
        @(negedge clk);
        tb_word = 32'h12345678;
        tb_held = 1'b1;
        repeat (4) @(negedge clk);
        nassert++;
        if (busy !== 1'b0 || overrun !== 1'b1 || (read_cnt - rc0) != 1) begin
            nfail++;
            $display("FAIL overrun_ignored: busy=%b overrun=%b reads=%0d, required 0 / 1 / 1", busy, overrun, read_cnt - rc0);
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1; addr = 23'h00077; is_old = 1'b0; back_mode = 1'b0;
        flash_mem_waitrequest = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        nassert++;
        if ({flash_mem_read, flash_mem_address, sample, sample_valid, busy, overrun, rd_error} !== '0) begin
            nfail++;
            $display("FAIL mid_reset: read=%b addr=%h sample=%h vld=%b busy=%b ovr=%b err=%b, required all 0",
                     flash_mem_read, flash_mem_address, sample, sample_valid, busy, overrun, rd_error);
        end
        rst_n = 1'b1;
        flash_mem_waitrequest = 1'b0;
        tb_held = 1'b0;
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'hDEADDEAD;
        repeat (2) @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = '0;
        repeat (2) @(negedge clk);
        request(23'h00078, 1'b1, 1'b0, 32'hC0DE4321, 0);
        @(negedge clk);
    endtask

`ifdef FLASH_RD_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        exp_q.push_back(16'h0000);
        start = 1'b1; addr = 23'h00123; is_old = 1'b0; back_mode = 1'b0;
        flash_mem_waitrequest = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (sample_valid !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        nassert++;
        if (cyc != 256) begin
            nfail++;
            $display("FAIL timeout_latency: pulse after %0d cycles, required 256", cyc);
        end
        nassert++;
        if (rd_error !== 1'b1 || sample !== 16'h0 || flash_mem_read !== 1'b0) begin
            nfail++;
            $display("FAIL timeout_flags: rd_error=%b sample=%h read=%b, required 1 / 0000 / 0", rd_error, sample, flash_mem_read);
        end
        tb_held = 1'b0;
        @(negedge clk);
        request(23'h00124, 1'b1, 1'b0, 32'h11112222, 0);
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_back_mode();
        test_stall();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
`ifdef FLASH_RD_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        nassert++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL scoreboard_drain: %0d samples outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
